// File: rtl/frame_former_par.sv
// frame_former_par
//   Reads DATA_W-bit payload words from an input FIFO and writes framed
//   words to an output FIFO. A frame is PREAMBLE_WORDS preamble words, an
//   optional sequence header word, then PAYLOAD_WORDS payload words.
//   Throughput is one word per cycle. A frame starts only when ENABLE is
//   high in IDLE. FRAME_CNT counts completed frames.
//
//   Optional build macro: FRAME_FORMER_SEQ_HEADER_EN
//     Inserts one header word, the low DATA_W bits of FRAME_CNT (zero
//     extended), between the preamble and the payload.
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   asynchronous reset, active low
//   ENABLE         in   permits a new frame to start (sampled in IDLE)
//   FIFO_IN_DATA   in   input FIFO read data, valid the cycle after FIFO_IN_RE
//   FIFO_IN_RE     out  input FIFO read enable
//   FIFO_IN_EMPTY  in   input FIFO empty flag
//   FIFO_OUT_DATA  out  output word
//   FIFO_OUT_WE    out  output FIFO write enable
//   FIFO_OUT_SOF   out  first preamble word marker
//   FIFO_OUT_EOF   out  last payload word marker
//   FIFO_OUT_FULL  in   output FIFO full flag
//   FRAME_CNT      out  completed frame count, wraps
//   BUSY           out  high in any state other than IDLE
module frame_former_par #(
    parameter int                               DATA_W         = 8,
    parameter int                               PREAMBLE_WORDS = 4,
    parameter logic [PREAMBLE_WORDS*DATA_W-1:0] PREAMBLE_VAL   = 32'h0123_4257,
    parameter int                               PAYLOAD_WORDS  = 6,
    parameter int                               CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] FIFO_IN_DATA,
    output logic              FIFO_IN_RE,
    input  logic              FIFO_IN_EMPTY,
    output logic [DATA_W-1:0] FIFO_OUT_DATA,
    output logic              FIFO_OUT_WE,
    output logic              FIFO_OUT_SOF,
    output logic              FIFO_OUT_EOF,
    input  logic              FIFO_OUT_FULL,
    output logic [CNT_W-1:0]  FRAME_CNT,
    output logic              BUSY
);

    localparam int PCW = $clog2(PREAMBLE_WORDS + 1);
    localparam int RCW = $clog2(PAYLOAD_WORDS + 1);

    localparam logic [PCW-1:0] PRE_LAST = PCW'(PREAMBLE_WORDS - 1);
    localparam logic [RCW-1:0] PAY_N    = RCW'(PAYLOAD_WORDS);
    localparam logic [RCW-1:0] PAY_LAST = RCW'(PAYLOAD_WORDS - 1);

`ifdef FRAME_FORMER_SEQ_HEADER_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_HEADER   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [PCW-1:0]    pre_cnt;
    logic [RCW-1:0]    req_cnt;
    logic [RCW-1:0]    wr_cnt;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_valid;
    logic              rd_pend;
    logic [CNT_W-1:0]  frame_cnt;

    logic [DATA_W-1:0] pre_word;
    logic [DATA_W-1:0] hold_word;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              sof;
    logic              eof;
    logic              drain;

    assign pre_word = PREAMBLE_VAL[int'(pre_cnt)*DATA_W +: DATA_W];

    // A word read last cycle is still on the FIFO read port; it becomes the
    // held word right away so a read can be written on the very next cycle.
    // It is copied into hold_reg in case FULL keeps it waiting.
    assign hold_word = rd_pend ? FIFO_IN_DATA : hold_reg;

`ifdef FRAME_FORMER_SEQ_HEADER_EN
    logic [DATA_W-1:0] hdr_word;
    generate
        if (CNT_W >= DATA_W) begin : g_hdr_trunc
            assign hdr_word = frame_cnt[DATA_W-1:0];
        end else begin : g_hdr_zext
            assign hdr_word = {{(DATA_W-CNT_W){1'b0}}, frame_cnt};
        end
    endgenerate
`endif

    always_comb begin
        state_nxt = state;
        re        = 1'b0;
        we        = 1'b0;
        wdata     = '0;
        sof       = 1'b0;
        eof       = 1'b0;
        drain     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (!FIFO_OUT_FULL) begin
                    we    = 1'b1;
                    wdata = pre_word;
                    sof   = (pre_cnt == '0);
                    if (pre_cnt == PRE_LAST) begin
`ifdef FRAME_FORMER_SEQ_HEADER_EN
                        state_nxt = ST_HEADER;
`else
                        state_nxt = ST_PAYLOAD;
`endif
                    end
                end
            end
`ifdef FRAME_FORMER_SEQ_HEADER_EN
            ST_HEADER: begin
                if (!FIFO_OUT_FULL) begin
                    we        = 1'b1;
                    wdata     = hdr_word;
                    state_nxt = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                // A read is only issued if its word can land: either the
                // hold slot is free or it is being drained this cycle.
                re = !FIFO_IN_EMPTY && (req_cnt < PAY_N) &&
                     (!hold_valid || !FIFO_OUT_FULL);
                if (hold_valid && !FIFO_OUT_FULL) begin
                    we    = 1'b1;
                    drain = 1'b1;
                    wdata = hold_word;
                    if (wr_cnt == PAY_LAST) begin
                        eof       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            pre_cnt    <= '0;
            req_cnt    <= '0;
            wr_cnt     <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            rd_pend    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= re;

            if (rd_pend) begin
                hold_reg <= FIFO_IN_DATA;
            end

            if (re) begin
                hold_valid <= 1'b1;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end

            if (state == ST_PREAMBLE) begin
                if (!FIFO_OUT_FULL) begin
                    pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
                end
            end else begin
                pre_cnt <= '0;
            end

            if (eof) begin
                req_cnt   <= '0;
                wr_cnt    <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else begin
                if (re) begin
                    req_cnt <= req_cnt + 1'b1;
                end
                if (drain) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    assign FIFO_IN_RE    = re;
    assign FIFO_OUT_WE   = we;
    assign FIFO_OUT_DATA = wdata;
    assign FIFO_OUT_SOF  = sof;
    assign FIFO_OUT_EOF  = eof;
    assign FRAME_CNT     = frame_cnt;
    assign BUSY          = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_former_par.sv
module tb_frame_former_par;

    localparam int          DW   = 8;
    localparam int          PRE  = 4;
    localparam int          PAY  = 6;
    localparam int          CW   = 16;
    localparam logic [31:0] PVAL = 32'h0123_4257;
`ifdef FRAME_FORMER_SEQ_HEADER_EN
    localparam int          FLEN = PRE + 1 + PAY;
`else
    localparam int          FLEN = PRE + PAY;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          ENABLE = 1'b0;
    logic [DW-1:0] FIFO_IN_DATA = '0;
    logic          FIFO_IN_RE;
    logic          FIFO_IN_EMPTY = 1'b1;
    logic [DW-1:0] FIFO_OUT_DATA;
    logic          FIFO_OUT_WE;
    logic          FIFO_OUT_SOF;
    logic          FIFO_OUT_EOF;
    logic          FIFO_OUT_FULL = 1'b0;
    logic [CW-1:0] FRAME_CNT;
    logic          BUSY;

    frame_former_par #(
        .DATA_W(DW),
        .PREAMBLE_WORDS(PRE),
        .PREAMBLE_VAL(PVAL),
        .PAYLOAD_WORDS(PAY),
        .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .FIFO_IN_DATA(FIFO_IN_DATA),
        .FIFO_IN_RE(FIFO_IN_RE),
        .FIFO_IN_EMPTY(FIFO_IN_EMPTY),
        .FIFO_OUT_DATA(FIFO_OUT_DATA),
        .FIFO_OUT_WE(FIFO_OUT_WE),
        .FIFO_OUT_SOF(FIFO_OUT_SOF),
        .FIFO_OUT_EOF(FIFO_OUT_EOF),
        .FIFO_OUT_FULL(FIFO_OUT_FULL),
        .FRAME_CNT(FRAME_CNT),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       pay;
    } exp_t;

    typedef struct {
        logic [7:0] base;
        bit         tog;
        bit         gap;
        int         exp_cnt;
        int         exp_len;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    exp_t       mon_e;

    int total = 0;
    int bad = 0;
    int frames = 0;
    int cyc = 0;
    int we_cnt = 0;
    int sof_seen = 0;
    int sof_cyc = 0;
    int eof_cyc = 0;
    int outst = 0;
    bit re_s = 1'b0;
    bit full_toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input FIFO model: registered read port, data valid the cycle after RE.
    always @(posedge CLK) begin
        cyc++;
        if (RESET && re_s && fifo_q.size() > 0) begin
            FIFO_IN_DATA <= fifo_q.pop_front();
        end
        #1;
        FIFO_IN_EMPTY = (fifo_q.size() == 0);
    end

    // Output FIFO backpressure: toggles every 2 cycles when enabled.
    always @(posedge CLK) begin
        #2;
        if (full_toggle) begin
            if (cyc % 2 == 0) FIFO_OUT_FULL = ~FIFO_OUT_FULL;
        end else begin
            FIFO_OUT_FULL = 1'b0;
        end
    end

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RESET) begin
            re_s = FIFO_IN_RE;
            if (FIFO_IN_RE) begin
                check("re_while_empty", 32'(FIFO_IN_EMPTY), 32'd0);
                check("re_hold_full", 32'(outst >= 1 && FIFO_OUT_FULL), 32'd0);
            end
            if (FIFO_OUT_WE) begin
                we_cnt++;
                check("we_while_full", 32'(FIFO_OUT_FULL), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h expected none", FIFO_OUT_DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", 32'(FIFO_OUT_DATA), 32'(mon_e.d));
                    check("sof", 32'(FIFO_OUT_SOF), 32'(mon_e.sof));
                    check("eof", 32'(FIFO_OUT_EOF), 32'(mon_e.eof));
                    if (mon_e.pay) outst--;
                end
                if (FIFO_OUT_SOF) begin
                    sof_seen++;
                    sof_cyc = cyc;
                end
                if (FIFO_OUT_EOF) eof_cyc = cyc;
            end
            if (FIFO_IN_RE) outst++;
        end else begin
            re_s  = 1'b0;
            outst = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_expected(input logic [7:0] base);
        logic [31:0] pv;
        pv = PVAL;
        for (int i = 0; i < PRE; i++)
            exp_q.push_back('{pv[i*8 +: 8], (i == 0), 1'b0, 1'b0});
`ifdef FRAME_FORMER_SEQ_HEADER_EN
        exp_q.push_back('{8'(frames), 1'b0, 1'b0, 1'b0});
`endif
        for (int i = 0; i < PAY; i++)
            exp_q.push_back('{base + 8'(i), 1'b0, (i == PAY - 1), 1'b1});
        frames++;
    endtask

    task automatic load_fifo(input logic [7:0] base, input int from, input int upto);
        for (int i = from; i < upto; i++) fifo_q.push_back(base + 8'(i));
    endtask

    task automatic wait_exp(input int n, input string name);
        int k;
        k = 0;
        while (exp_q.size() > n && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        check(name, 32'(exp_q.size() <= n), 32'd1);
    endtask

    task automatic wait_sof(input int n, input string name);
        int k;
        k = 0;
        while (sof_seen < n && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        check(name, 32'(sof_seen >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge CLK);
        while (BUSY && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        check(name, 32'(BUSY), 32'd0);
    endtask

    task automatic run_frame(input vec_t v);
        int w0;
        int w;
        tick();
        full_toggle = v.tog;
        push_expected(v.base);
        load_fifo(v.base, 0, v.gap ? 3 : PAY);
        w0 = we_cnt;
        ENABLE = 1'b1;
        wait_sof(sof_seen + 1, "frame_start");
        tick();
        ENABLE = 1'b0;
        if (v.gap) begin
            wait_exp(PAY - 3, "gap_first3");
            w = we_cnt;
            repeat (20) tick();
            check("gap_no_we", 32'(we_cnt - w), 32'd0);
            check("gap_busy", 32'(BUSY), 32'd1);
            load_fifo(v.base, 3, PAY);
        end
        wait_exp(0, "frame_drained");
        wait_idle("frame_idle");
        full_toggle = 1'b0;
        check("frame_cnt", 32'(FRAME_CNT), 32'(v.exp_cnt));
        check("frame_len", 32'(we_cnt - w0), 32'(v.exp_len));
    endtask

    vec_t tbl[4];
    int   s0;
    int   gap_cycles;

    initial begin
        tbl[0] = '{8'h10, 1'b0, 1'b0, 1, FLEN};
        tbl[1] = '{8'h20, 1'b1, 1'b0, 2, FLEN};
        tbl[2] = '{8'h30, 1'b0, 1'b1, 3, FLEN};
        tbl[3] = '{8'h40, 1'b1, 1'b1, 4, FLEN};

        // Reset state while held in reset.
        #3;
        check("rst_we", 32'(FIFO_OUT_WE), 32'd0);
        check("rst_re", 32'(FIFO_IN_RE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_cnt", 32'(FRAME_CNT), 32'd0);
        tick();
        RESET = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        // Back-to-back frames, ENABLE dropped during frame 2 payload.
        tick();
        s0 = sof_seen;
        push_expected(8'h50);
        push_expected(8'h60);
        load_fifo(8'h50, 0, PAY);
        load_fifo(8'h60, 0, PAY);
        ENABLE = 1'b1;
        wait_sof(s0 + 2, "b2b_second_sof");
        gap_cycles = sof_cyc - eof_cyc;
        check("b2b_idle_gap", 32'(gap_cycles), 32'd2);
        wait_exp(3, "b2b_in_payload");
        tick();
        ENABLE = 1'b0;
        wait_exp(0, "b2b_drained");
        wait_idle("b2b_idle");
        repeat (10) tick();
        check("b2b_sof_count", 32'(sof_seen - s0), 32'd2);
        check("b2b_frame_cnt", 32'(FRAME_CNT), 32'd6);
        check("b2b_busy_stays_low", 32'(BUSY), 32'd0);

        // Asynchronous reset while streaming payload.
        tick();
        push_expected(8'h70);
        load_fifo(8'h70, 0, PAY);
        ENABLE = 1'b1;
        wait_sof(sof_seen + 1, "rst_frame_start");
        tick();
        ENABLE = 1'b0;
        wait_exp(4, "rst_in_payload");
        @(negedge CLK);
        #2;
        check("pre_rst_busy", 32'(BUSY), 32'd1);
        RESET = 1'b0;
        #1;
        check("arst_we", 32'(FIFO_OUT_WE), 32'd0);
        check("arst_re", 32'(FIFO_IN_RE), 32'd0);
        check("arst_sof", 32'(FIFO_OUT_SOF), 32'd0);
        check("arst_eof", 32'(FIFO_OUT_EOF), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_cnt", 32'(FRAME_CNT), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        frames = 0;
        tick();
        RESET = 1'b1;
        tick();

        // Recovery after reset: one clean frame.
        run_frame(tbl[0]);

        repeat (5) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
